stm1_deframer: RTL and testbench

STM1_DEFRAMER -- requirements
Module: stm1_deframer

---
 rtl/stm1_deframer_pkg.sv | 28 ++
 rtl/stm1_deframer_a1a2_detect.sv | 47 ++++
 rtl/stm1_deframer.sv | 184 ++++++++++++++++++
 tb/tb_stm1_deframer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stm1_deframer_pkg.sv
// Shared constants and types for the STM-1 deframer.
//
// Frame geometry: 9 rows x 270 columns, transmitted row-major.
// Columns 0..8 carry section overhead. Columns 9..269 carry the VC-4,
// which is taken as column-aligned (the AU-4 pointer is not interpreted).
package stm1_deframer_pkg;

  // Frame geometry.
  localparam int STM1_Length      = 270;  // columns per row
  localparam int STM1_Width       = 9;    // rows per frame
  localparam int vc4_Length       = 261;  // VC-4 columns per row
  localparam int SOH_COLS         = 9;    // overhead columns per row
  localparam int STM1_FRAME_BYTES = 2430; // STM1_Length * STM1_Width

  // Framing bytes: A1 x3 followed by A2 x3 at row 0, columns 0..5.
  localparam logic [7:0] A1_BYTE = 8'hF6;
  localparam logic [7:0] A2_BYTE = 8'h28;

  // Default number of consecutive errored framing patterns tolerated in SYNC.
  localparam int LOSS_FRAMES_DEFAULT = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } framer_state_t;

endpackage

// File: rtl/stm1_deframer_a1a2_detect.sv
// A1/A2 framing pattern detector.
//
// Keeps the last five accepted bytes in a shift register. Together with the
// current byte this forms a six-byte window, which is compared against
// F6 F6 F6 28 28 28 (oldest first). match_o is combinational on the
// current byte, so it is valid in the same cycle that byte is accepted.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - synchronous active-low reset, clears history to 0x00
//   en_i    - shift enable (byte accepted this cycle)
//   data_i  - current byte
//   match_o - 1 when the window equals the framing pattern and en_i is high
module stm1_a1a2_detect
  import stm1_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic       match_o
);

  localparam logic [47:0] PATTERN = {A1_BYTE, A1_BYTE, A1_BYTE,
                                     A2_BYTE, A2_BYTE, A2_BYTE};

  logic [39:0] hist_q;
  logic [39:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (en_i) begin
      hist_d = {hist_q[31:0], data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign match_o = en_i && ({hist_q, data_i} == PATTERN);

endmodule

// File: rtl/stm1_deframer.sv
// STM-1 deframer: locates the A1/A2 framing pattern, tracks row/column of
// every accepted byte and emits the VC-4 bytes (columns 9..269) while in SYNC.
//
// Alignment FSM:
//   HUNT    - six-byte window search; a hit loads the counters so the next
//             byte is row 0, col 6, and moves to PRESYNC.
//   PRESYNC - one confirmation at row 0, col 5 of the next frame:
//             hit -> SYNC, miss -> HUNT.
//   SYNC    - pattern checked at row 0, col 5 of every frame. Consecutive
//             misses are counted; LOSS_FRAMES of them return to HUNT with a
//             one-cycle oof_pulse.
//
// Handshake: in_valid qualifies in_data; there is no back-pressure. Every
// accepted payload byte appears on out_* exactly one clock later with
// out_valid high; out_valid is low on every other cycle.
//
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   in_valid, in_data   - received line byte stream
//   out_valid, out_data - VC-4 byte, registered
//   out_row, out_col    - VC-4 position (0..8, 0..260)
//   out_sof             - VC-4 row 0, column 0
//   locked              - FSM in SYNC
//   oof_pulse           - one-cycle pulse on SYNC -> HUNT
//   dbg_state           - FSM state (framer_state_t encoding)
//   dbg_err_cnt         - consecutive errored-frame count
module stm1_deframer
  import stm1_deframer_pkg::*;
#(
  parameter int LOSS_FRAMES = LOSS_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [3:0] out_row,
  output logic [8:0] out_col,
  output logic       out_sof,
  output logic       locked,
  output logic       oof_pulse,
  output logic [1:0] dbg_state,
  output logic [7:0] dbg_err_cnt
);

  localparam logic [8:0] COL_LAST  = 9'(STM1_Length - 1);
  localparam logic [3:0] ROW_LAST  = 4'(STM1_Width - 1);
  localparam logic [8:0] COL_SOH   = 9'(SOH_COLS);
  localparam logic [8:0] COL_CHECK = 9'd5;
  localparam logic [8:0] COL_RELOAD = 9'd6;
  localparam logic [7:0] ERR_LAST  = 8'(LOSS_FRAMES - 1);

  framer_state_t state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [8:0]    col_q, col_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [3:0]    out_row_q, out_row_d;
  logic [8:0]    out_col_q, out_col_d;
  logic          out_sof_q, out_sof_d;
  logic          oof_q, oof_d;

  logic          match;
  logic          at_check;

  stm1_a1a2_detect u_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (in_valid),
    .data_i  (in_data),
    .match_o (match)
  );

  // The framing window ends on the byte at row 0, col 5.
  assign at_check = (row_q == 4'd0) && (col_q == COL_CHECK);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    err_cnt_d   = err_cnt_q;
    oof_d       = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = 8'h00;
    out_row_d   = 4'd0;
    out_col_d   = 9'd0;
    out_sof_d   = 1'b0;

    if (in_valid) begin
      // Free-running position counters; HUNT may override with a reload.
      if (col_q == COL_LAST) begin
        col_d = 9'd0;
        row_d = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
      end else begin
        col_d = col_q + 9'd1;
      end

      case (state_q)
        HUNT: begin
          if (match) begin
            state_d   = PRESYNC;
            row_d     = 4'd0;
            col_d     = COL_RELOAD;
            err_cnt_d = 8'd0;
          end
        end

        PRESYNC: begin
          err_cnt_d = 8'd0;
          if (at_check) begin
            state_d = match ? SYNC : HUNT;
          end
        end

        SYNC: begin
          if (at_check) begin
            if (match) begin
              err_cnt_d = 8'd0;
            end else if (err_cnt_q == ERR_LAST) begin
              state_d   = HUNT;
              err_cnt_d = 8'd0;
              oof_d     = 1'b1;
            end else begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
          // Payload columns are never the check column, so a SYNC exit at
          // col 5 never coincides with a payload byte.
          if (col_q >= COL_SOH) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_row_d   = row_q;
            out_col_d   = col_q - COL_SOH;
            out_sof_d   = (row_q == 4'd0) && (col_q == COL_SOH);
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      row_q       <= 4'd0;
      col_q       <= 9'd0;
      err_cnt_q   <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_row_q   <= 4'd0;
      out_col_q   <= 9'd0;
      out_sof_q   <= 1'b0;
      oof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_sof_q   <= out_sof_d;
      oof_q       <= oof_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_sof     = out_sof_q;
  assign oof_pulse   = oof_q;
  assign locked      = (state_q == SYNC);
  assign dbg_state   = state_q;
  assign dbg_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_stm1_deframer.sv
// Bench for stm1_deframer. Frames are built by the bench; for every frame
// the caller states whether payload is expected (the FSM is in SYNC after
// the col-5 check), and each driven payload byte pushes its expected
// {data,row,col,sof} into a queue popped by the negedge monitor.
module tb_stm1_deframer;
  import stm1_deframer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_row;
  logic [8:0] out_col;
  logic       out_sof;
  logic       locked;
  logic       oof_pulse;
  logic [1:0] dbg_state;
  logic [7:0] dbg_err_cnt;

  stm1_deframer #(.LOSS_FRAMES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_sof    (out_sof),
    .locked     (locked),
    .oof_pulse  (oof_pulse),
    .dbg_state  (dbg_state),
    .dbg_err_cnt(dbg_err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [21:0] exp_q[$];   // {data[7:0], row[3:0], col[8:0], sof}
  logic        exp_vld;    // byte accepted at last posedge was payload
  logic        exp_oof;    // byte accepted at last posedge triggers loss
  logic        mon_en;
  int          n_cmp;
  int          n_err;
  int          fnum;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] d, input bit pay,
                       input logic [21:0] e, input bit oof);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    exp_vld = v && pay;
    exp_oof = v && oof;
    if (v && pay) exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_vld = 1'b0;
    exp_oof = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_row", out_row, 0);
    check_val("rst_out_col", out_col, 0);
    check_val("rst_out_sof", out_sof, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_oof_pulse", oof_pulse, 0);
    check_val("rst_state", dbg_state, 32'(HUNT));
    check_val("rst_err_cnt", dbg_err_cnt, 0);
  endtask

  function automatic logic [7:0] frame_byte(input int f, input int r,
                                            input int c, input bit corrupt);
    if (r == 0 && c < 3) return A1_BYTE;
    if (r == 0 && c < 6) return corrupt ? 8'h29 : A2_BYTE;
    if (c < SOH_COLS) return 8'h11;
    return 8'((f * 31 + r * 17 + c * 7) ^ 32'h5A);
  endfunction

  // corrupt  : A2 bytes replaced
  // sync_exp : payload of this frame expected (also locked after col 5)
  // oof_exp  : this frame's col-5 byte triggers the loss of alignment
  // gaps     : insert random idle cycles (in_valid=0)
  // rst_at   : byte index at which a 1-cycle reset is applied (-1 none)
  // exp_err  : expected err_cnt after col 5 (-1 skip)
  task automatic send_frame(input bit corrupt, input bit sync_exp,
                            input bit oof_exp, input bit gaps,
                            input int rst_at, input int exp_err);
    bit sync_now;
    sync_now = sync_exp;
    for (int r = 0; r < STM1_Width; r++) begin
      for (int c = 0; c < STM1_Length; c++) begin
        logic [7:0]  b;
        logic [21:0] e;
        int          oc;
        if (rst_at == r * STM1_Length + c) begin
          do_reset();
          check_reset_outputs();
          sync_now = 1'b0;
        end
        if (gaps && ($urandom_range(0, 1) == 1)) drive(1'b0, 8'h00, 1'b0, 22'd0, 1'b0);
        b  = frame_byte(fnum, r, c, corrupt);
        oc = c - SOH_COLS;
        e  = {b, r[3:0], oc[8:0], (r == 0 && c == SOH_COLS)};
        drive(1'b1, b, sync_now && (c >= SOH_COLS), e,
              oof_exp && r == 0 && c == 5);
        if (r == 0 && c == 5) begin
          check_val("locked_after_a2", locked, sync_exp);
          if (exp_err >= 0) check_val("err_cnt", dbg_err_cnt, exp_err);
        end
      end
    end
    fnum++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("out_valid", out_valid, exp_vld);
      check_val("oof_pulse", oof_pulse, exp_oof);
      if (exp_vld && exp_q.size() > 0) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if (out_valid) begin
          check_val("out_data", out_data, e[21:14]);
          check_val("out_row", out_row, e[13:10]);
          check_val("out_col", out_col, e[9:1]);
          check_val("out_sof", out_sof, e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    exp_vld  = 1'b0;
    exp_oof  = 1'b0;
    mon_en   = 1'b0;
    n_cmp    = 0;
    n_err    = 0;
    fnum     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outputs();
    mon_en = 1'b1;

    // Two clean frames from reset: HUNT hit in frame 1, SYNC from frame 2.
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(1'b0, 1'b1, 1'b0, 1'b0, -1, 0);

    // Three errored frames stay in SYNC, a good frame clears the count.
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 1);
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 2);
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 3);
    send_frame(1'b0, 1'b1, 1'b0, 1'b0, -1, 0);

    // Four errored frames: loss at col 5 of the fourth, then re-lock.
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 1);
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 2);
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 3);
    send_frame(1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    check_val("state_after_loss", dbg_state, 32'(HUNT));
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(1'b0, 1'b1, 1'b0, 1'b0, -1, 0);

    // One-cycle reset in the middle of payload, then fresh HUNT/PRESYNC.
    send_frame(1'b0, 1'b1, 1'b0, 1'b0, 3 * STM1_Length + 100, 0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(1'b0, 1'b1, 1'b0, 1'b0, -1, 0);

    // Random prefix, then clean frames.
    do_reset();
    check_reset_outputs();
    repeat (1000) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 22'd0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(1'b0, 1'b1, 1'b0, 1'b0, -1, 0);

    // Same clean sequence with random in_valid gaps.
    do_reset();
    check_reset_outputs();
    fnum = 0;
    send_frame(1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(1'b0, 1'b1, 1'b0, 1'b1, -1, 0);

    // Flush: one idle cycle so the last payload byte is observed.
    drive(1'b0, 8'h00, 1'b0, 22'd0, 1'b0);
    mon_en = 1'b0;
    check_val("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
